// File: rtl/lcd_bcd_writer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bcd_writer
// Purpose  : Streams a BCD reading, optional decimal point and a degree/unit
//            suffix to an HD44780-style character LCD over an 8-bit bus.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bcd_writer #(
    parameter int NDIG        = 4,
    parameter int DP_POS      = 1,
    parameter int EN_CYCLES   = 2,
    parameter int WAIT_CYCLES = 3,
    parameter int CLR_WAIT    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd,
    input  logic              unit_f,
    output logic              busy,
    output logic              done,
    output logic [7:0]        lcd_data,
    output logic              rs,
    output logic              rw,
    output logic              en
);

    localparam int c_max_a   = (EN_CYCLES > WAIT_CYCLES) ? EN_CYCLES : WAIT_CYCLES;
    localparam int c_max_cyc = (c_max_a > CLR_WAIT) ? c_max_a : CLR_WAIT;
    localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

    localparam logic [c_cnt_w-1:0] c_en_load   = c_cnt_w'(EN_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(WAIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_clr_load  = c_cnt_w'(CLR_WAIT - 1);
    localparam logic [2:0]         c_top_idx   = 3'(NDIG - 1);
    localparam logic [2:0]         c_dp_idx    = 3'(DP_POS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_CLEAR  = 3'd2,
        S_HOME   = 3'd3,
        S_DIGIT  = 3'd4,
        S_POINT  = 3'd5,
        S_SUFFIX = 3'd6,
        S_FIN    = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic                gap_q, gap_d;
    logic                init_q, init_d;
    logic [4*NDIG-1:0]   bcd_q, bcd_d;
    logic                unit_q, unit_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                en_q, en_d;
    logic                rs_q, rs_d;
    logic [7:0]          data_q, data_d;

    logic [NDIG-1:0]     w_lead_zero;
    logic                w_launch;
    state_t              w_nxt_state;
    logic [2:0]          w_nxt_idx;
    logic [3:0]          w_nib;
    logic                w_blank;
    logic [7:0]          w_byte;
    logic                w_byte_rs;

    // w_lead_zero[i]: digit i and every more significant digit are zero
    always_comb begin : p_lead_zero
        logic run;
        run         = 1'b1;
        w_lead_zero = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            run            = run & (bcd_q[4*i +: 4] == 4'd0);
            w_lead_zero[i] = run;
        end
    end

    always_comb begin
        w_nib     = 4'd0;
        w_blank   = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (i == int'(w_nxt_idx)) begin
                w_nib   = bcd_q[4*i +: 4];
                w_blank = w_lead_zero[i] && (i > DP_POS);
            end
        end
        w_byte    = 8'h00;
        w_byte_rs = 1'b1;
        case (w_nxt_state)
            S_INIT:  begin w_byte = 8'h0C; w_byte_rs = 1'b0; end
            S_CLEAR: begin w_byte = 8'h01; w_byte_rs = 1'b0; end
            S_HOME:  begin w_byte = 8'h02; w_byte_rs = 1'b0; end
            S_DIGIT: begin
                if (w_blank)
                    w_byte = 8'h20;
                else if (w_nib > 4'd9)
                    w_byte = 8'h2D;
                else
                    w_byte = {4'h3, w_nib};
            end
            S_POINT: w_byte = 8'h2E;
            S_SUFFIX: begin
                case (w_nxt_idx)
                    3'd0:    w_byte = 8'h20;
                    3'd1:    w_byte = 8'hDF;
                    default: w_byte = unit_q ? 8'h46 : 8'h43;
                endcase
            end
            default: w_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        init_d      = init_q;
        bcd_d       = bcd_q;
        unit_d      = unit_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        en_d        = en_q;
        rs_d        = rs_q;
        data_d      = data_q;
        w_launch    = 1'b0;
        w_nxt_state = S_IDLE;
        w_nxt_idx   = 3'd0;

        case (state_q)
            S_IDLE, S_FIN: begin
                // FIN doubles as an idle slot so back-to-back frames lose no cycle
                if (start) begin
                    w_launch    = 1'b1;
                    w_nxt_state = init_q ? S_HOME : S_INIT;
                    bcd_d       = bcd;
                    unit_d      = unit_f;
                    busy_d      = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (!gap_q) begin
                    if (cnt_q == '0) begin
                        gap_d = 1'b1;
                        en_d  = 1'b0;
                        cnt_d = (state_q == S_CLEAR || state_q == S_HOME) ? c_clr_load : c_wait_load;
                    end else begin
                        cnt_d = cnt_q - c_cnt_w'(1);
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_cnt_w'(1);
                end else begin
                    case (state_q)
                        S_INIT: begin
                            w_launch    = 1'b1;
                            w_nxt_state = S_CLEAR;
                        end
                        S_CLEAR, S_HOME: begin
                            w_launch    = 1'b1;
                            w_nxt_state = S_DIGIT;
                            w_nxt_idx   = c_top_idx;
                        end
                        S_DIGIT: begin
                            w_launch = 1'b1;
                            if (idx_q == 3'd0) begin
                                w_nxt_state = S_SUFFIX;
                            end else if ((DP_POS > 0) && (idx_q == c_dp_idx)) begin
                                w_nxt_state = S_POINT;
                                w_nxt_idx   = idx_q;
                            end else begin
                                w_nxt_state = S_DIGIT;
                                w_nxt_idx   = idx_q - 3'd1;
                            end
                        end
                        S_POINT: begin
                            w_launch    = 1'b1;
                            w_nxt_state = S_DIGIT;
                            w_nxt_idx   = idx_q - 3'd1;
                        end
                        S_SUFFIX: begin
                            if (idx_q == 3'd2) begin
                                state_d = S_FIN;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                init_d  = 1'b1;
                                gap_d   = 1'b0;
                            end else begin
                                w_launch    = 1'b1;
                                w_nxt_state = S_SUFFIX;
                                w_nxt_idx   = idx_q + 3'd1;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase

        if (w_launch) begin
            state_d = w_nxt_state;
            idx_d   = w_nxt_idx;
            en_d    = 1'b1;
            gap_d   = 1'b0;
            cnt_d   = c_en_load;
            rs_d    = w_byte_rs;
            data_d  = w_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
            init_q  <= 1'b0;
            bcd_q   <= '0;
            unit_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            init_q  <= init_d;
            bcd_q   <= bcd_d;
            unit_q  <= unit_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign lcd_data = data_q;
    assign rs       = rs_q;
    assign rw       = 1'b0;
    assign en       = en_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bcd_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bcd_writer
// Purpose  : Self-checking bench for lcd_bcd_writer (DP_POS=1 and DP_POS=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bcd_writer;
    localparam int EN_C   = 2;
    localparam int WAIT_C = 3;
    localparam int CLR_C  = 5;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] bcd     = 16'h0000;
    logic        unit_f  = 1'b0;
    logic        busy_a, done_a, rs_a, rw_a, en_a;
    logic        busy_b, done_b, rs_b, rw_b, en_b;
    logic [7:0]  data_a, data_b;

    always #5 clk = ~clk;

    lcd_bcd_writer #(.NDIG(4), .DP_POS(1), .EN_CYCLES(EN_C), .WAIT_CYCLES(WAIT_C), .CLR_WAIT(CLR_C)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bcd(bcd), .unit_f(unit_f),
        .busy(busy_a), .done(done_a), .lcd_data(data_a), .rs(rs_a), .rw(rw_a), .en(en_a));

    lcd_bcd_writer #(.NDIG(4), .DP_POS(0), .EN_CYCLES(EN_C), .WAIT_CYCLES(WAIT_C), .CLR_WAIT(CLR_C)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bcd(bcd), .unit_f(unit_f),
        .busy(busy_b), .done(done_b), .lcd_data(data_b), .rs(rs_b), .rw(rw_b), .en(en_b));

    bit         sel_b = 1'b0;
    wire        m_busy = sel_b ? busy_b : busy_a;
    wire        m_done = sel_b ? done_b : done_a;
    wire        m_en   = sel_b ? en_b   : en_a;
    wire        m_rs   = sel_b ? rs_b   : rs_a;
    wire        m_rw   = sel_b ? rw_b   : rw_a;
    wire [7:0]  m_data = sel_b ? data_b : data_a;

    int n_cmp  = 0;
    int n_fail = 0;

    // Bus monitor: records each strobed byte, its enable width and its gap
    logic [8:0] got_q[$];
    int         hi_q[$];
    int         lo_q[$];
    logic [8:0] cur_byte = 9'h000;
    logic       prev_en  = 1'b0;
    bit         have_cur = 1'b0;
    int         cur_hi = 0, cur_lo = 0, busy_cnt = 0, done_cnt = 0, unstable = 0, rw_bad = 0;
    int         clr_gen = 0, seen_gen = 0;

    always @(negedge clk) begin
        if (clr_gen != seen_gen) begin
            seen_gen = clr_gen;
            got_q.delete(); hi_q.delete(); lo_q.delete();
            have_cur = 1'b0; busy_cnt = 0; done_cnt = 0; unstable = 0; rw_bad = 0;
        end
        if (m_rw !== 1'b0) rw_bad++;
        if (m_en === 1'b1 && prev_en !== 1'b1) begin
            if (have_cur) begin hi_q.push_back(cur_hi); lo_q.push_back(cur_lo); end
            cur_byte = {m_rs, m_data};
            got_q.push_back(cur_byte);
            cur_hi = 1; cur_lo = 0; have_cur = 1'b1;
        end else if (m_busy === 1'b1) begin
            if (m_en === 1'b1) cur_hi++; else cur_lo++;
            if ({m_rs, m_data} !== cur_byte) unstable++;
        end
        if (m_done === 1'b1) begin
            done_cnt++;
            if (have_cur) begin hi_q.push_back(cur_hi); lo_q.push_back(cur_lo); end
            have_cur = 1'b0;
        end
        if (m_busy === 1'b1) busy_cnt++;
        prev_en = m_en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the frame as the list of {rs,byte} the display should receive
    logic [8:0] exp_q[$];
    int         exp_busy;

    function automatic int gap_of(input logic [8:0] b);
        return (b == 9'h001 || b == 9'h002) ? CLR_C : WAIT_C;
    endfunction

    task automatic build_exp(input int dp, input logic [15:0] v, input bit u, input bit first);
        bit seen_nz;
        int d;
        exp_q.delete();
        seen_nz = 1'b0;
        if (first) begin exp_q.push_back(9'h00C); exp_q.push_back(9'h001); end
        else exp_q.push_back(9'h002);
        for (int i = 3; i >= 0; i--) begin
            d = int'((v >> (4*i)) & 16'h000F);
            if (dp > 0 && i == dp - 1) exp_q.push_back(9'h12E);
            if (d != 0) seen_nz = 1'b1;
            if (!seen_nz && i > dp)  exp_q.push_back(9'h120);
            else if (d > 9)          exp_q.push_back(9'h12D);
            else                     exp_q.push_back(9'h130 + 9'(d));
        end
        exp_q.push_back(9'h120);
        exp_q.push_back(9'h1DF);
        exp_q.push_back(u ? 9'h146 : 9'h143);
        exp_busy = 0;
        foreach (exp_q[k]) exp_busy += EN_C + gap_of(exp_q[k]);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int i = 0; i < 4; i++)
            r[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic set_start(input bit b, input logic val);
        if (b) start_b = val; else start_a = val;
    endtask

    task automatic launch(input bit b, input logic [15:0] v, input bit u);
        @(posedge clk) #1;
        sel_b = b; bcd = v; unit_f = u;
        set_start(b, 1'b1);
    endtask

    // Expects start already raised; runs the frame to FIN and checks it
    task automatic finish_frame(input bit b, input int dp, input logic [15:0] v, input bit u,
                                input bit first, input bit disturb,
                                input bit chain, input logic [15:0] nv, input bit nu);
        int c;
        build_exp(dp, v, u, first);
        @(posedge clk) #1;
        set_start(b, 1'b0);
        check("busy_first_cycle", m_busy, 1);
        check("en_first_cycle", m_en, 1);
        check("done_low_in_frame", m_done, 0);
        if (disturb) begin bcd = 16'h9999; unit_f = ~u; end
        c = 0;
        while (c < 400 && m_done !== 1'b1) begin
            if (disturb) set_start(b, (c == 5 || c == 17 || c == 30));
            @(posedge clk) #1;
            c++;
        end
        check("frame_done_seen", m_done, 1);
        check("busy_low_at_done", m_busy, 0);
        if (chain) begin bcd = nv; unit_f = nu; set_start(b, 1'b1); end
        @(negedge clk) #1;
        check("byte_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("byte%0d", k), got_q[k], exp_q[k]);
        check("width_count", hi_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < hi_q.size() && k < lo_q.size(); k++) begin
            check($sformatf("en_width%0d", k), hi_q[k], EN_C);
            check($sformatf("gap_width%0d", k), lo_q[k], gap_of(exp_q[k]));
        end
        check("busy_cycles", busy_cnt, exp_busy);
        check("done_pulses", done_cnt, 1);
        check("bus_stable", unstable, 0);
        check("rw_zero", rw_bad, 0);
        clr_gen++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},   en_a,   0);
        check({tag, "_rs"},   rs_a,   0);
        check({tag, "_rw"},   rw_a,   0);
        check({tag, "_data"}, data_a, 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
    endtask

    initial begin
        logic [15:0] v;
        bit          u;
        int          c;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check("rst_b_busy", busy_b, 0);
        check("rst_b_en", en_b, 0);
        rst = 1'b0;

        // First frame chained straight into the second from the FIN cycle
        launch(1'b0, 16'h0253, 1'b0);
        finish_frame(1'b0, 1, 16'h0253, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1000, 1'b1);
        finish_frame(1'b0, 1, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        launch(1'b0, 16'h00A0, 1'b0);
        finish_frame(1'b0, 1, 16'h00A0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        launch(1'b0, 16'h0420, 1'b0);
        finish_frame(1'b0, 1, 16'h0420, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            v = rand_bcd();
            u = 1'($urandom_range(0, 1));
            launch(1'b0, v, u);
            finish_frame(1'b0, 1, v, u, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        end

        // Reset in the middle of the 4th byte aborts the frame
        launch(1'b0, 16'h0368, 1'b0);
        @(posedge clk) #1;
        start_a = 1'b0;
        c = 0;
        while (c < 200 && got_q.size() < 4) begin
            @(posedge clk) #1;
            c++;
        end
        check("abort_at_byte4", got_q.size(), 4);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(posedge clk) #1;
        rst = 1'b0;
        clr_gen++;
        launch(1'b0, 16'h0368, 1'b0);
        finish_frame(1'b0, 1, 16'h0368, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);

        // No decimal point variant
        launch(1'b1, 16'h0007, 1'b0);
        finish_frame(1'b1, 0, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            v = rand_bcd();
            u = 1'($urandom_range(0, 1));
            launch(1'b1, v, u);
            finish_frame(1'b1, 0, v, u, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/lcd_bcd_writer.md
LCD_BCD_WRITER -- requirements
Module: lcd_bcd_writer

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of BCD digits displayed; legal range 1..8.
REQ-002 SHALL have parameter DP_POS, default 1: number of fractional digits; 0 = no decimal point; legal range 0..NDIG-1.
REQ-003 SHALL have parameter EN_CYCLES, default 2: en high width per byte, in clk cycles; minimum 1.
REQ-004 SHALL have parameter WAIT_CYCLES, default 3: en low gap after each ordinary byte; minimum 1.
REQ-005 SHALL have parameter CLR_WAIT, default 5: en low gap after the clear (0x01) and home (0x02) commands; minimum 1.
REQ-006 SHALL have the ports listed below. Reset is rst, asynchronous, active-high; the clock is clk.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  frame request, sampled on the clk edge
- bcd  in  4*NDIG  digits; most significant digit (MSD) in the top nibble
- unit_f  in  1  0 = Celsius suffix 'C', 1 = Fahrenheit suffix 'F'
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- lcd_data  out  8  LCD data bus
- rs  out  1  0 = command, 1 = character
- rw  out  1  LCD read/write select, constant 0
- en  out  1  LCD enable strobe

Function
REQ-007 All outputs SHALL be registered.
REQ-008 States: IDLE, INIT, CLEAR, HOME, DIGIT, POINT, SUFFIX, FIN.
REQ-009 Start acceptance:
- start is accepted only in IDLE.
- On acceptance, bcd and unit_f are captured into internal registers.
- start while busy=1 SHALL be ignored.
- Input changes after capture SHALL NOT affect the current frame.
REQ-010 Frame start timing: in the cycle after acceptance, busy=1 and en=1 with the first byte on lcd_data.
REQ-011 Byte timing:
- en=1 for EN_CYCLES cycles, then en=0 for WAIT_CYCLES cycles (CLR_WAIT cycles after 0x01 or 0x02).
- lcd_data and rs SHALL stay stable over both phases.
- The next byte starts in the cycle immediately after the gap.
REQ-012 First frame after reset: command 0x0C (INIT), then command 0x01 (CLEAR). Every later frame: command 0x02 (HOME) only.
- An internal init flag SHALL be set when the first frame completes.
REQ-013 Digit bytes (DIGIT state):
- Sent MSD first, rs=1.
- Each byte is 0x30+nibble for nibble values 0..9.
- A nibble value of 10..15 SHALL be sent as 0x2D ('-').
REQ-014 Leading-zero blanking: zero digits more significant than the first nonzero digit SHALL be sent as 0x20. The least significant integer digit (index DP_POS) SHALL never be blanked.
REQ-015 When DP_POS>0, byte 0x2E SHALL be inserted immediately before the DP_POS least significant digits.
REQ-016 Suffix bytes, all rs=1: 0x20, then 0xDF, then 0x43 ('C') or 0x46 ('F') per the captured unit_f.
REQ-017 Byte counts:
- First frame: 2 + NDIG + (DP_POS>0) + 3 bytes.
- Later frames: 1 + NDIG + (DP_POS>0) + 3 bytes.
REQ-018 Frame end (FIN):
- In the cycle after the last gap cycle: done=1 for exactly one cycle, busy=0, return to IDLE.
- A start in that cycle is accepted.
REQ-019 rw SHALL be 0 at all times.

Reset
REQ-020 While rst=1, outputs SHALL be: en=0, rs=0, rw=0, lcd_data=0x00, busy=0, done=0; FSM in IDLE; init flag cleared; all timing counters at 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately. The next frame SHALL include INIT and CLEAR again.

Verification (NDIG=4, DP_POS=1, EN_CYCLES=2, WAIT_CYCLES=3, CLR_WAIT=5 unless noted)
REQ-022 Reset, then start with bcd=0x0253, unit_f=0 -> bytes 0C,01,20,32,35,2E,33,20,DF,43; busy high for 52 cycles; one done pulse.
REQ-023 Second frame, bcd=0x1000, unit_f=1 -> bytes 02,31,30,30,2E,30,20,DF,46; busy high for 47 cycles.
REQ-024 bcd=0x00A0 -> digit bytes 20,20,2D,2E,30 (nibble A shows '-'; blanking stops at a non-zero digit).
REQ-025 Extra start pulses and a bcd change to 0x9999 mid-frame -> frame content unchanged; exactly one done pulse.
REQ-026 rst pulse during the 4th byte -> outputs immediately take the REQ-020 values; next start emits 0C,01 first.
REQ-027 DP_POS=0, bcd=0x0007 -> digit bytes 20,20,20,37; no 0x2E byte.
